// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the puzzle-solver CPU sequencer.
//   - opcode encodings for control-flow and datapath instructions
//   - bit positions of the opcode and jump-target fields in an instruction
//   - sequencer state encodings (plain constants so older tools can read them)
//   - is_ctrl(): true for the opcodes the sequencer resolves itself
package cpu_sequencer_pkg;

  // Instruction fields
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int TGT_HI = 27;
  localparam int TGT_LO = 20;

  // Datapath opcodes
  localparam logic [3:0] OP_LI    = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_CHECK = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_REF   = 4'h4;
  localparam logic [3:0] OP_ROTL  = 4'h5;
  localparam logic [3:0] OP_ROTR  = 4'h6;
  // Control-flow opcodes, resolved inside the sequencer
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_ZNJ   = 4'hA;

  // Sequencer states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_FLAG = 3'd3;
  localparam logic [2:0] ST_HALT      = 3'd4;

  function automatic logic is_ctrl(input logic [3:0] opc);
    return (opc == OP_JMP) || (opc == OP_JNZ) || (opc == OP_ZNJ);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bus between the sequencer, the instruction memory and the datapath.
//   pc          instruction memory address (sequencer -> memory)
//   op          instruction word, combinational from memory
//   exec_op     latched instruction presented to the datapath
//   exec_valid  exec_op is valid
//   exec_ready  datapath accepts exec_op
//   flag_valid  datapath reports a CHECK result this cycle
//   flag_nz     CHECK result is nonzero (qualified by flag_valid)
// master = sequencer side, slave = memory/datapath side.
interface cpu_sequencer_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] pc;
  logic [31:0]     op;
  logic [31:0]     exec_op;
  logic            exec_valid;
  logic            exec_ready;
  logic            flag_valid;
  logic            flag_nz;

  modport master (
    output pc, exec_op, exec_valid,
    input  op, exec_ready, flag_valid, flag_nz
  );

  modport slave (
    input  pc, exec_op, exec_valid,
    output op, exec_ready, flag_valid, flag_nz
  );
endinterface

// File: rtl/seq_retire_counter.sv
// Saturating retired-instruction counter.
//   clk, rst  clock and synchronous active-high reset
//   inc       one instruction retired this cycle
//   count     retired instructions, sticks at all-ones
module seq_retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer for the puzzle-solver CPU.
// Owns the program counter, resolves JMP/JNZ/ZNJ itself and hands every
// other opcode to the datapath over a valid/ready handshake. Keeps the
// latest CHECK result (nz_q) for conditional jumps.
//   clk, rst     clock, synchronous active-high reset
//   start        one-cycle pulse, begins execution at pc 0 (IDLE/HALT only)
//   bus          cpu_sequencer_if.master: imem address/data, exec handshake,
//                CHECK flag return
//   busy         not in IDLE and not in HALT
//   halted       terminal loop detected
//   instr_count  saturating count of retired instructions
// Optional build macro HALT_DETECT_EN: a JMP to itself, or a JMP that
// bounces straight back to the JMP retired just before it, parks the
// sequencer in HALT with pc frozen on that JMP. Without the macro such
// loops simply run forever and halted is tied low.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  cpu_sequencer_if.master        bus,
  output logic                   busy,
  output logic                   halted,
  output logic [CNT_W-1:0]       instr_count
);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            nz_q, nz_d;

  logic [3:0]      opc;
  logic [7:0]      tgt_field;
  logic [PC_W-1:0] tgt, pc_inc;
  logic            ctrl, exec_valid, hs, retire, start_ok, halt_hit;

  assign opc       = ir_q[OPC_HI:OPC_LO];
  assign tgt_field = ir_q[TGT_HI:TGT_LO];
  assign tgt       = tgt_field[PC_W-1:0];
  assign pc_inc    = pc_q + PC_W'(1);
  assign ctrl      = is_ctrl(opc);

  assign exec_valid = (state_q == ST_ISSUE) && !ctrl;
  assign hs         = exec_valid && bus.exec_ready;
  assign retire     = ((state_q == ST_ISSUE) && ctrl) || hs;
  assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_HALT));

`ifdef HALT_DETECT_EN
  // Last retired instruction, kept only if it was a JMP.
  logic            pj_vld_q, pj_vld_d;
  logic [PC_W-1:0] pj_pc_q, pj_pc_d, pj_tgt_q, pj_tgt_d;

  assign halt_hit = (opc == OP_JMP) &&
                    ((tgt == pc_q) ||
                     (pj_vld_q && (pj_pc_q == tgt) && (pj_tgt_q == pc_q)));

  always_comb begin
    pj_vld_d = pj_vld_q;
    pj_pc_d  = pj_pc_q;
    pj_tgt_d = pj_tgt_q;
    if (start_ok) begin
      pj_vld_d = 1'b0;
    end else if (retire) begin
      pj_vld_d = (opc == OP_JMP);
      pj_pc_d  = pc_q;
      pj_tgt_d = tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pj_vld_q <= 1'b0;
      pj_pc_q  <= '0;
      pj_tgt_q <= '0;
    end else begin
      pj_vld_q <= pj_vld_d;
      pj_pc_q  <= pj_pc_d;
      pj_tgt_q <= pj_tgt_d;
    end
  end

  assign halted = (state_q == ST_HALT);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    // Flag is captured whatever the state, so a jump always sees the
    // most recent CHECK result.
    nz_d    = bus.flag_valid ? bus.flag_nz : nz_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        ir_d    = bus.op;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (ctrl) begin
          state_d = ST_FETCH;
          case (opc)
            OP_JMP: begin
              if (halt_hit) state_d = ST_HALT;
              else          pc_d    = tgt;
            end
            OP_JNZ:  pc_d = nz_q ? tgt : pc_inc;
            OP_ZNJ:  pc_d = nz_q ? pc_inc : tgt;
            default: pc_d = pc_inc;
          endcase
        end else if (bus.exec_ready) begin
          pc_d = pc_inc;
          // A CHECK whose flag comes back with the handshake needs no wait.
          state_d = ((opc == OP_CHECK) && !bus.flag_valid) ? ST_WAIT_FLAG
                                                            : ST_FETCH;
        end
      end
      ST_WAIT_FLAG: begin
        if (bus.flag_valid) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      nz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      nz_q    <= nz_d;
    end
  end

  seq_retire_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .count (instr_count)
  );

  assign bus.pc         = pc_q;
  assign bus.exec_valid = exec_valid;
  assign bus.exec_op    = exec_valid ? ir_q : '0;
  assign busy           = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                          (state_q == ST_WAIT_FLAG);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios with literal expectations plus
// randomized programs and handshakes, all checked every cycle against an
// instruction-level reference model.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam int PC_W   = 8;
  localparam int CNT_W  = 5;
  localparam int CNT_MX = (1 << CNT_W) - 1;
`ifdef HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  // model phases
  localparam int M_OFF = 0, M_FETCH = 1, M_EXEC = 2, M_FLAG = 3, M_HALT = 4;

  logic clk = 1'b0;
  logic rst, start, rdy, fv, fnz;
  logic busy, halted;
  logic [CNT_W-1:0] instr_count;
  logic [31:0] mem [256];

  int nvec = 0, nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.PC_W(PC_W)) bus ();
  assign bus.op         = mem[bus.pc];
  assign bus.exec_ready = rdy;
  assign bus.flag_valid = fv;
  assign bus.flag_nz    = fnz;

  cpu_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus.master),
    .busy        (busy),
    .halted      (halted),
    .instr_count (instr_count)
  );

  function automatic logic [31:0] mk(input logic [3:0] o, input logic [7:0] t,
                                     input logic [19:0] p);
    return {o, t, p};
  endfunction

  function automatic bit ctl(input logic [31:0] w);
    return (w[31:28] == OP_JMP) || (w[31:28] == OP_JNZ) || (w[31:28] == OP_ZNJ);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      if (nerr < 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (architectural, one step per edge) ----
  int         mph = M_OFF;
  logic [7:0] mpc = '0, ppc = '0, ptgt = '0;
  logic [31:0] minstr = '0;
  bit         mnz = 1'b0, pj = 1'b0;
  int         mcnt = 0;

  task automatic m_retire(input logic [3:0] o, input logic [7:0] t);
    if (mcnt < CNT_MX) mcnt++;
    pj   = (o == OP_JMP);
    ppc  = mpc;
    ptgt = t;
  endtask

  task automatic model_step();
    logic [3:0] o;
    logic [7:0] t;
    bit taken, hlt;
    o = minstr[31:28];
    t = minstr[27:20];
    if (rst) begin
      mph = M_OFF; mpc = '0; mnz = 1'b0; mcnt = 0; pj = 1'b0; minstr = '0;
      return;
    end
    case (mph)
      M_OFF, M_HALT: if (start) begin mph = M_FETCH; mpc = '0; pj = 1'b0; end
      M_FETCH: begin minstr = mem[mpc]; mph = M_EXEC; end
      M_EXEC: begin
        if (ctl(minstr)) begin
          taken = (o == OP_JMP) || (o == OP_JNZ && mnz) || (o == OP_ZNJ && !mnz);
          hlt   = HALT_EN && (o == OP_JMP) &&
                  ((t == mpc) || (pj && ppc == t && ptgt == mpc));
          m_retire(o, t);
          if (hlt) mph = M_HALT;
          else begin mpc = taken ? t : mpc + 8'd1; mph = M_FETCH; end
        end else if (rdy) begin
          m_retire(o, t);
          mpc = mpc + 8'd1;
          mph = (o == OP_CHECK && !fv) ? M_FLAG : M_FETCH;
        end
      end
      M_FLAG: if (fv) mph = M_FETCH;
      default: mph = M_OFF;
    endcase
    if (fv) mnz = fnz;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = (mph == M_EXEC) && !ctl(minstr);
      cmp("pc", 32'(bus.pc), 32'(mpc));
      cmp("exec_valid", 32'(bus.exec_valid), 32'(ev));
      if (ev) cmp("exec_op", bus.exec_op, minstr);
      cmp("busy", 32'(busy), 32'(mph == M_FETCH || mph == M_EXEC || mph == M_FLAG));
      cmp("halted", 32'(halted), 32'(mph == M_HALT));
      cmp("instr_count", 32'(instr_count), 32'(mcnt));
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = mk(OP_ADD, 8'd0, 20'(i));
  endtask

  function automatic logic [3:0] rnd_op();
    int r;
    r = $urandom_range(0, 11);
    case (r)
      7, 10:   return OP_JMP;
      8:       return OP_JNZ;
      9:       return OP_ZNJ;
      11:      return 4'hF;
      default: return 4'(r);
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; rdy = 1'b0; fv = 1'b0; fnz = 1'b0;
    clear_mem();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    cmp("rst_pc", 32'(bus.pc), 0);
    cmp("rst_valid", 32'(bus.exec_valid), 0);
    cmp("rst_exec_op", bus.exec_op, 0);
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_cnt", 32'(instr_count), 0);

    // 0:JMP 5, 5:LI
    clear_mem();
    mem[0] = mk(OP_JMP, 8'd5, 20'h0);
    mem[5] = mk(OP_LI, 8'd0, 20'h00ABC);
    rdy = 1'b1;
    do_reset();
    pulse_start();
    cmp("t1_pc0", 32'(bus.pc), 0);
    tick();
    cmp("t1_jmp_novalid", 32'(bus.exec_valid), 0);
    tick();
    cmp("t1_pc5", 32'(bus.pc), 5);
    cmp("t1_fetch_novalid", 32'(bus.exec_valid), 0);
    tick();
    cmp("t1_li_valid", 32'(bus.exec_valid), 1);
    cmp("t1_li_op", bus.exec_op, 32'h0000_0ABC);
    tick();
    cmp("t1_pc6", 32'(bus.pc), 6);
    cmp("t1_cnt2", 32'(instr_count), 2);
    cmp("t1_valid_drop", 32'(bus.exec_valid), 0);

    // CHECK at 3 with late ready and later flag, then 4:JNZ 20
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      mem[0]  = mk(OP_JMP, 8'd3, 20'h0);
      mem[3]  = mk(OP_CHECK, 8'd0, 20'h00C0C);
      mem[4]  = mk(OP_JNZ, 8'd20, 20'h0);
      mem[5]  = mk(OP_JMP, 8'd5, 20'h0);
      mem[20] = mk(OP_JMP, 8'd20, 20'h0);
      rdy = 1'b0;
      do_reset();
      pulse_start();
      tick(); tick(); tick();
      cmp("t2_check_valid", 32'(bus.exec_valid), 1);
      cmp("t2_check_pc", 32'(bus.pc), 3);
      repeat (4) tick();
      rdy = 1'b1; tick(); rdy = 1'b0;
      cmp("t2_pc4", 32'(bus.pc), 4);
      tick();
      fv = 1'b1; fnz = (k == 0); tick(); fv = 1'b0; fnz = 1'b0;
      tick(); tick();
      cmp("t2_jnz_pc", 32'(bus.pc), (k == 0) ? 20 : 5);
    end

    // ZNJ 3 with nz_q = 0, then nz_q = 1
    clear_mem();
    mem[0] = mk(OP_ZNJ, 8'd3, 20'h0);
    do_reset();
    pulse_start(); tick(); tick();
    cmp("t3_znj_taken", 32'(bus.pc), 3);
    do_reset();
    fv = 1'b1; fnz = 1'b1; tick(); fv = 1'b0; fnz = 1'b0;
    pulse_start(); tick(); tick();
    cmp("t3_znj_fall", 32'(bus.pc), 1);

    // pc wrap 255 -> 0
    clear_mem();
    mem[0]   = mk(OP_JMP, 8'hFF, 20'h0);
    mem[255] = mk(OP_ROTL, 8'd0, 20'h12345);
    rdy = 1'b1;
    do_reset();
    pulse_start(); tick(); tick();
    cmp("t4_pc255", 32'(bus.pc), 255);
    tick(); tick();
    cmp("t4_wrap", 32'(bus.pc), 0);

    // reset during a stalled handshake
    clear_mem();
    mem[0] = mk(OP_JMP, 8'd1, 20'h0);
    mem[1] = mk(OP_STORE, 8'd0, 20'h5);
    rdy = 1'b0;
    do_reset();
    pulse_start(); tick(); tick(); tick();
    cmp("t5_stall_valid", 32'(bus.exec_valid), 1);
    cmp("t5_cnt1", 32'(instr_count), 1);
    do_reset();
    cmp("t5_valid0", 32'(bus.exec_valid), 0);
    cmp("t5_pc0", 32'(bus.pc), 0);
    cmp("t5_busy0", 32'(busy), 0);
    cmp("t5_cnt0", 32'(instr_count), 0);

    // two-JMP loop 71 <-> 72
    clear_mem();
    mem[0]  = mk(OP_JMP, 8'd71, 20'h0);
    mem[71] = mk(OP_JMP, 8'd72, 20'h0);
    mem[72] = mk(OP_JMP, 8'd71, 20'h0);
    do_reset();
    pulse_start();
    repeat (6) tick();
`ifdef HALT_DETECT_EN
    cmp("t6_halted", 32'(halted), 1);
    cmp("t6_pc72", 32'(bus.pc), 72);
    cmp("t6_busy0", 32'(busy), 0);
    repeat (10) tick();
    cmp("t6_frozen", 32'(bus.pc), 72);
`else
    for (int i = 0; i < 100; i++) begin
      cmp("t6_loop_pc", 32'(bus.pc == 71 || bus.pc == 72), 1);
      cmp("t6_not_halted", 32'(halted), 0);
      tick();
    end
`endif

    // randomized programs and handshake behaviour
    for (int trial = 0; trial < 8; trial++) begin
      for (int i = 0; i < 256; i++)
        mem[i] = mk(rnd_op(),
                    ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31)),
                    20'($urandom));
      do_reset();
      for (int c = 0; c < 500; c++) begin
        rdy   = ($urandom_range(0, 3) != 0);
        fv    = ($urandom_range(0, 4) == 0);
        fnz   = 1'($urandom);
        start = ($urandom_range(0, 24) == 0);
        rst   = ($urandom_range(0, 299) == 0);
        tick();
      end
      rst = 1'b0; start = 1'b0; fv = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
